// File: rtl/fft_in_loader.sv
// fft_in_loader
// Serial-to-parallel input loader for the 32-point DIT FFT core.
// Samples arrive one per handshake in natural order and land in
// bit-reversed slots. A complete frame is then presented in parallel
// to the butterfly array and held until the core acknowledges it.
// An in_last that arrives before the final index discards the frame.

module fft_in_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_r,
    input  logic [DATA_WIDTH-1:0]         in_i,
    input  logic                          in_last,
    output logic                          frame_valid,
    input  logic                          frame_ack,
    output logic [DEPTH*DATA_WIDTH-1:0]   frame_r,
    output logic [DEPTH*DATA_WIDTH-1:0]   frame_i,
    output logic [ADDR_WIDTH-1:0]         sample_cnt,
    output logic                          err_pulse
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   cnt_next;
    logic                    err_next;
    logic                    fv_next;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_slot;
    logic                    handshake;

    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_i [DEPTH];

    // Reverse the bit order of a sample index to find its storage slot.
    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        for (int b = 0; b < ADDR_WIDTH; b++) begin
            r[b] = v[ADDR_WIDTH-1-b];
        end
        return r;
    endfunction

    // Ready is a pure state decode, also forced low while reset is held.
    assign in_ready  = (state == FILL) && rst_n;
    assign handshake = in_valid && in_ready;
    assign wr_slot   = bitrev(sample_cnt);

    // Next-state logic: count samples, detect frame completion and early in_last.
    always_comb begin
        state_next = state;
        cnt_next   = sample_cnt;
        err_next   = 1'b0;
        wr_en      = 1'b0;
        case (state)
            FILL: begin
                if (handshake) begin
                    if (sample_cnt == LAST_IDX) begin
                        wr_en      = 1'b1;
                        cnt_next   = '0;
                        state_next = FULL;
                    end else if (in_last) begin
                        err_next   = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        wr_en      = 1'b1;
                        cnt_next   = sample_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (frame_ack) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
                cnt_next   = '0;
            end
        endcase
        fv_next = (state_next == FULL);
    end

    // State, counter and status flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FILL;
            sample_cnt  <= '0;
            frame_valid <= 1'b0;
            err_pulse   <= 1'b0;
        end else begin
            state       <= state_next;
            sample_cnt  <= cnt_next;
            frame_valid <= fv_next;
            err_pulse   <= err_next;
        end
    end

    // Sample storage: cleared on reset, written at the bit-reversed slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
                mem_i[k] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_slot] <= in_r;
            mem_i[wr_slot] <= in_i;
        end
    end

    // Each storage slot drives its frame bus lane directly.
    for (genvar k = 0; k < DEPTH; k++) begin : g_pack
        assign frame_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[k];
        assign frame_i[k*DATA_WIDTH +: DATA_WIDTH] = mem_i[k];
    end

endmodule
